// File: rtl/inst_loader.sv
// Instruction-memory loader: accepts a counted stream of words over a
// valid/ready handshake and writes them to consecutive addresses.
module inst_loader #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] BaseAddr,
    input  logic [A:0]   Count,
    input  logic         Abort,
    input  logic         InValid,
    input  logic [W-1:0] InData,
    output logic         InReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         Busy,
    output logic         Done,
    output logic         Error,
    output logic [W-1:0] Checksum
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [A+1:0] MEM_WORDS = {2'b01, {A{1'b0}}};
    localparam logic [A:0]   REM_ONE   = {{A{1'b0}}, 1'b1};

    logic [1:0]   state_q, state_d;
    logic [A-1:0] addr_q, addr_d;
    logic [A:0]   rem_q, rem_d;
    logic         wr_en_q, wr_en_d;
    logic [A-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;
    logic         error_q, error_d;
    logic [W-1:0] checksum_q, checksum_d;

    logic         in_ready;
    logic         hs;
    logic [A+1:0] end_addr;

    // Extra headroom bits so BaseAddr+Count cannot overflow the range check
    assign end_addr = {2'b00, BaseAddr} + {1'b0, Count};
    assign in_ready = (state_q == S_LOAD) && !Abort;
    assign hs       = InValid && in_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        error_d    = error_q;
        checksum_d = checksum_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    checksum_d = '0;
                    error_d    = 1'b0;
                    if (Count == '0) begin
                        state_d = S_DONE;
                    end else if (end_addr > MEM_WORDS) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = BaseAddr;
                        rem_d   = Count;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else if (hs) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = addr_q;
                    wr_data_d  = InData;
                    addr_d     = addr_q + A'(1);
                    rem_d      = rem_q - REM_ONE;
                    checksum_d = checksum_q + InData;
                    if (rem_q == REM_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            error_q    <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            error_q    <= error_d;
            checksum_q <= checksum_d;
        end
    end

    assign InReady  = in_ready;
    assign WrEn     = wr_en_q;
    assign WrAddr   = wr_addr_q;
    assign WrData   = wr_data_q;
    assign Busy     = (state_q == S_LOAD);
    assign Done     = (state_q == S_DONE);
    assign Error    = error_q;
    assign Checksum = checksum_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: directed and randomized loads against a
// transaction-level model of the expected memory writes and checksum.
module tb_inst_loader;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [9:0]  BaseAddr;
    logic [10:0] Count;
    logic        Abort;
    logic        InValid;
    logic [8:0]  InData;
    logic        InReady;
    logic        WrEn;
    logic [9:0]  WrAddr;
    logic [8:0]  WrData;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [8:0]  Checksum;

    int total;
    int passed;
    int fails;
    logic [8:0] fixed_q[$];

    inst_loader #(.A(10), .W(9)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .BaseAddr(BaseAddr), .Count(Count), .Abort(Abort),
        .InValid(InValid), .InData(InData), .InReady(InReady),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Busy(Busy), .Done(Done), .Error(Error),
        .Checksum(Checksum)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wren"}, 32'(WrEn), 0);
        check({tag, "_waddr"}, 32'(WrAddr), 0);
        check({tag, "_wdata"}, 32'(WrData), 0);
        check({tag, "_ready"}, 32'(InReady), 0);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_done"}, 32'(Done), 0);
        check({tag, "_err"}, 32'(Error), 0);
        check({tag, "_csum"}, 32'(Checksum), 0);
    endtask

    // mode: 0 = InValid always 1, 1 = alternating 1,0,..., 2 = random
    // abort_at: number of handshakes after which Abort is raised (-1 none)
    task automatic do_load(input int base, input int cnt, input int mode,
                           input int abort_at);
        int addr, rem, sum, hs_n, guard;
        bit err, v, ab, hs, fin;
        logic [8:0] d;
        Start    = 1'b1;
        BaseAddr = 10'(base);
        Count    = 11'(cnt);
        Abort    = 1'($urandom);
        InValid  = 1'($urandom);
        InData   = 9'($urandom);
        #1 check("ready_idle", 32'(InReady), 0);
        step();
        Start = 1'b0; Abort = 1'b0; InValid = 1'b0;
        err = (base + cnt) > 1024;
        check("error", 32'(Error), 32'(err));
        check("csum_clr", 32'(Checksum), 0);
        check("wren_start", 32'(WrEn), 0);
        if (cnt == 0 || err) begin
            check("done_imm", 32'(Done), 1);
            check("busy_imm", 32'(Busy), 0);
            InValid = 1'b1;
            #1 check("ready_done", 32'(InReady), 0);
            InValid = 1'b0;
            step();
            check("done_end", 32'(Done), 0);
            check("wren_none", 32'(WrEn), 0);
            check("err_hold", 32'(Error), 32'(err));
            return;
        end
        check("busy", 32'(Busy), 1);
        check("done_lo", 32'(Done), 0);
        addr = base; rem = cnt; sum = 0; hs_n = 0; fin = 0; guard = 0;
        while (!fin && guard < 5000) begin
            case (mode)
                0: v = 1'b1;
                1: v = (guard % 2 == 0);
                default: v = 1'($urandom);
            endcase
            ab = (abort_at >= 0 && hs_n == abort_at);
            d = (fixed_q.size() > 0) ? fixed_q.pop_front() : 9'($urandom);
            InValid  = v;
            InData   = d;
            Abort    = ab;
            Start    = 1'($urandom);
            BaseAddr = 10'($urandom);
            Count    = 11'($urandom);
            hs = v && !ab;
            #1 check("ready", 32'(InReady), 32'(!ab));
            step();
            Start = 1'b0; Abort = 1'b0; InValid = 1'b0;
            check("wren", 32'(WrEn), 32'(hs));
            if (hs) begin
                check("waddr", 32'(WrAddr), 32'(addr));
                check("wdata", 32'(WrData), 32'(d));
                sum = (sum + d) % 512;
                addr++;
                rem--;
                hs_n++;
            end
            check("csum", 32'(Checksum), 32'(sum));
            if (ab) begin
                check("abort_busy", 32'(Busy), 0);
                check("abort_done", 32'(Done), 0);
                fin = 1'b1;
                step();
                check("abort_wren", 32'(WrEn), 0);
                check("abort_idle", 32'(Busy), 0);
                check("abort_nodone", 32'(Done), 0);
            end else if (rem == 0) begin
                check("fin_done", 32'(Done), 1);
                check("fin_busy", 32'(Busy), 0);
                fin = 1'b1;
                step();
                check("post_done", 32'(Done), 0);
                check("post_wren", 32'(WrEn), 0);
                check("post_busy", 32'(Busy), 0);
            end else begin
                check("mid_busy", 32'(Busy), 1);
                check("mid_done", 32'(Done), 0);
            end
            guard++;
        end
        if (!fin) check("timeout", 0, 1);
    endtask

    initial begin
        total = 0; passed = 0; fails = 0;
        Reset = 1'b0; Start = 1'b1; BaseAddr = 10'd5; Count = 11'd3;
        Abort = 1'b0; InValid = 1'b1; InData = 9'h1ff;
        step();
        step();
        check_all_zero("reset");
        Reset = 1'b1; Start = 1'b0; InValid = 1'b0;
        step();

        fixed_q = '{9'h001, 9'h1ff, 9'h0aa};
        do_load(0, 3, 0, -1);
        check("b2b_csum", 32'(Checksum), 32'h0aa);
        do_load(1020, 4, 1, -1);
        check("edge_err", 32'(Error), 0);
        do_load(1021, 4, 0, -1);
        do_load(0, 0, 0, -1);
        check("cnt0_csum", 32'(Checksum), 0);
        do_load(10, 5, 0, 2);
        do_load(3, 2, 0, -1);
        do_load(1023, 1, 2, -1);

        // Reset mid-load with a handshake offered in the reset cycle
        Start = 1'b1; BaseAddr = 10'd5; Count = 11'd4;
        step();
        Start = 1'b0; InValid = 1'b1; InData = 9'h055;
        step();
        check("pre_rst_wren", 32'(WrEn), 1);
        Reset = 1'b0; InData = 9'h066;
        step();
        check_all_zero("midrst");
        Reset = 1'b1; InValid = 1'b0;
        #1 check("rst_ready", 32'(InReady), 0);
        do_load(7, 1, 0, -1);

        for (int i = 0; i < 14; i++) begin
            int c, b, ab;
            c = $urandom_range(0, 20);
            if (c >= 2 && $urandom_range(0, 2) == 0)
                b = 1024 - c + $urandom_range(0, 1);
            else
                b = $urandom_range(0, 1023);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, c) : -1;
            do_load(b, c, 2, ab);
        end
        do_load(0, 1024, 0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter A, default 10, instruction-memory address width (2**A words).
REQ-002 Parameter W, default 9, instruction word width.
REQ-003 The module SHALL have one clock, Clk; reset, Reset, SHALL be synchronous and active-low.
REQ-004 Clk  input  1  system clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous active-low reset.
REQ-006 Start  input  1  begin a load; sampled only in IDLE.
REQ-007 BaseAddr  input  A  first memory address to write; latched on accepted Start.
REQ-008 Count  input  A+1  number of words to load, 0..2**A; latched on accepted Start.
REQ-009 Abort  input  1  cancel an in-progress load.
REQ-010 InValid  input  1  InData holds a valid instruction word.
REQ-011 InData  input  W  instruction word from the source.
REQ-012 InReady  output  1  loader accepts a word this cycle.
REQ-013 WrEn  output  1  instruction-memory write strobe.
REQ-014 WrAddr  output  A  instruction-memory write address.
REQ-015 WrData  output  W  instruction-memory write data.
REQ-016 Busy  output  1  high while in LOAD.
REQ-017 Done  output  1  one-cycle completion pulse.
REQ-018 Error  output  1  range error on last Start.
REQ-019 Checksum  output  W  sum of accepted words, mod 2**W.

Function
REQ-020 States SHALL be IDLE, LOAD, DONE; Done=1 only in DONE, Busy=1 only in LOAD, InReady=1 only in LOAD with Abort=0.
REQ-021 In IDLE with Start=1: Checksum and Error SHALL clear; if Count==0, next state DONE; else if BaseAddr+Count > 2**A (computed at A+2 bits), Error SHALL set and next state DONE with no writes; else latch address=BaseAddr, remaining=Count, next state LOAD.
REQ-022 A handshake SHALL occur on a rising edge with InValid=1 and InReady=1; with InReady=0, InData SHALL be ignored.
REQ-023 Per handshake: WrEn=1, WrAddr=current address, WrData=InData in the following cycle only (registered, 1-cycle latency); address+1, remaining-1, Checksum+=InData mod 2**W.
REQ-024 WrEn SHALL be 0 in every cycle not following a handshake; InValid gaps SHALL stall without writes.
REQ-025 Handshake with remaining==1 SHALL move to DONE next cycle; InReady SHALL be 0 from that cycle.
REQ-026 The final write SHALL address 2**A-1 at most; the address SHALL never wrap within a load.
REQ-027 DONE SHALL last exactly one cycle, then IDLE.
REQ-028 Abort=1 in LOAD SHALL return to IDLE next cycle without Done; Abort SHALL beat a simultaneous InValid (no handshake, no write); a write registered from the previous cycle SHALL still complete.
REQ-029 Start outside IDLE and Abort outside LOAD SHALL be ignored.
REQ-030 Checksum and Error SHALL hold their values until the next accepted Start.

Reset
REQ-031 Reset=0 at a rising edge SHALL force IDLE, WrEn=0, WrAddr=0, WrData=0, InReady=0, Busy=0, Done=0, Error=0, Checksum=0, overriding all other inputs.
REQ-032 Reset during LOAD SHALL cancel any pending registered write: WrEn=0 in the cycle after the reset edge.

Verification
REQ-033 BaseAddr=0, Count=3, words 0x001,0x1FF,0x0AA back-to-back -> WrEn on three consecutive cycles at addr 0,1,2; Done=1 in the same cycle as the third WrEn; Checksum=0x0AA.
REQ-034 BaseAddr=1020, Count=4, InValid toggled 1,0,1,0,... -> writes only to 1020..1023, none in gap cycles; Error=0; Done pulses once.
REQ-035 BaseAddr=1021, Count=4 -> Error=1, Done pulse next cycle, InReady never 1, no WrEn.
REQ-036 Count=0 -> Done=1 in the cycle after Start, Checksum=0, no WrEn.
REQ-037 Count=5; after 2 handshakes, Abort=1 with InValid=1 -> exactly 2 writes, no Done, Busy=0 next cycle; next Start is accepted.
REQ-038 Reset=0 mid-LOAD, one cycle after a handshake -> all outputs 0 in the next cycle, state IDLE; subsequent load of Count=1 completes normally.
